turkey_gun_ctrl: RTL and testbench

Converts digital joystick directions into the 6-bit absolute gun crosshair position (gun_h, gun_v) consumed by the williams2 game core's gun inputs. It sits directly upstream of williams2 in the top level and is paced by the core's cnt_4ms_o strobe. Movement accelerates while a direction is held, is clamped to the playfield range, and can be recentred on demand.

---
 rtl/turkey_gun_pkg.sv | 26 ++
 rtl/gun_axis.sv | 165 ++++++++++++++++
 rtl/turkey_gun_ctrl.sv | 96 +++++++++
 tb/tb_turkey_gun_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/turkey_gun_pkg.sv
// Shared types and default constants for the joystick-to-gun-crosshair
// controller. Positions are 6-bit absolute coordinates as consumed by the
// williams2 gun inputs.
package turkey_gun_pkg;

    typedef logic [5:0] gun_pos_t;

    // Per-axis movement state: IDLE (no direction), SLOW (initial divided
    // rate while the hold counter runs), FAST (accelerated rate).
    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_SLOW = 2'd1,
        AX_FAST = 2'd2
    } axis_state_t;

    // Resolved direction of one axis after cancelling opposing inputs.
    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_MINUS = 2'd1,
        DIR_PLUS  = 2'd2
    } dir_t;

    localparam int GUN_MAX_C    = 62;
    localparam int GUN_CENTER_C = 31;

endpackage

// File: rtl/gun_axis.sv
// One crosshair axis: direction resolve, IDLE/SLOW/FAST acceleration FSM,
// rate divider and hold counters, clamped position register.
//
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   tick_i      one-cycle movement strobe (already edge-detected)
//   recenter_i  snap to GUN_CENTER, FSM to IDLE; wins over tick_i
//   plus_i      increasing-coordinate input held (right / down)
//   minus_i     decreasing-coordinate input held (left / up)
//   pos_o       registered position
//   changed_o   combinational: pos_o will take a new value at the next edge
//   state_o     current FSM state (debug visibility)
module gun_axis
    import turkey_gun_pkg::*;
#(
    parameter int GUN_MAX     = GUN_MAX_C,
    parameter int GUN_CENTER  = GUN_CENTER_C,
    parameter int DIV_SLOW    = 3,
    parameter int DIV_FAST    = 1,
    parameter int ACCEL_TICKS = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tick_i,
    input  logic        recenter_i,
    input  logic        plus_i,
    input  logic        minus_i,
    output gun_pos_t    pos_o,
    output logic        changed_o,
    output axis_state_t state_o
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int DIV_W   = $clog2(DIV_MAX) + 1;
    localparam int HOLD_W  = $clog2(ACCEL_TICKS) + 1;

    localparam logic [DIV_W-1:0]  DIV_SLOW_LAST = DIV_W'(DIV_SLOW - 1);
    localparam logic [DIV_W-1:0]  DIV_FAST_LAST = DIV_W'(DIV_FAST - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST     = HOLD_W'(ACCEL_TICKS - 1);
    localparam gun_pos_t          POS_MAX       = gun_pos_t'(GUN_MAX);
    localparam gun_pos_t          POS_CENTER    = gun_pos_t'(GUN_CENTER);

    axis_state_t       state_q, state_d;
    dir_t              dir_q, dir_d;
    dir_t              dir_in;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    gun_pos_t          pos_q, pos_d;
    logic              step;

    // Holding both opposing inputs cancels to no movement.
    always_comb begin
        dir_in = DIR_NONE;
        if (plus_i && !minus_i) begin
            dir_in = DIR_PLUS;
        end else if (minus_i && !plus_i) begin
            dir_in = DIR_MINUS;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        div_d   = div_q;
        hold_d  = hold_q;
        step    = 1'b0;

        if (recenter_i) begin
            state_d = AX_IDLE;
            dir_d   = DIR_NONE;
            div_d   = '0;
            hold_d  = '0;
        end else if (tick_i) begin
            case (state_q)
                AX_IDLE: begin
                    if (dir_in != DIR_NONE) begin
                        step    = 1'b1;
                        dir_d   = dir_in;
                        div_d   = '0;
                        hold_d  = '0;
                        state_d = AX_SLOW;
                    end
                end
                AX_SLOW, AX_FAST: begin
                    if (dir_in == DIR_NONE) begin
                        state_d = AX_IDLE;
                        dir_d   = DIR_NONE;
                        div_d   = '0;
                        hold_d  = '0;
                    end else if (dir_in != dir_q) begin
                        // Reversal responds immediately and restarts the ramp.
                        step    = 1'b1;
                        dir_d   = dir_in;
                        div_d   = '0;
                        hold_d  = '0;
                        state_d = AX_SLOW;
                    end else if (state_q == AX_SLOW) begin
                        if (div_q == DIV_SLOW_LAST) begin
                            step  = 1'b1;
                            div_d = '0;
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                        // Promotion restarts the divider at the fast rate.
                        if (hold_q == HOLD_LAST) begin
                            state_d = AX_FAST;
                            div_d   = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end else begin
                        if (div_q == DIV_FAST_LAST) begin
                            step  = 1'b1;
                            div_d = '0;
                        end else begin
                            div_d = div_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = AX_IDLE;
                    dir_d   = DIR_NONE;
                    div_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Steps at the playfield edges are swallowed; the FSM still advances.
    always_comb begin
        pos_d = pos_q;
        if (recenter_i) begin
            pos_d = POS_CENTER;
        end else if (step) begin
            if (dir_d == DIR_PLUS && pos_q < POS_MAX) begin
                pos_d = pos_q + 6'd1;
            end else if (dir_d == DIR_MINUS && pos_q != 6'd0) begin
                pos_d = pos_q - 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= AX_IDLE;
            dir_q   <= DIR_NONE;
            div_q   <= '0;
            hold_q  <= '0;
            pos_q   <= POS_CENTER;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            hold_q  <= hold_d;
            pos_q   <= pos_d;
        end
    end

    assign pos_o     = pos_q;
    assign changed_o = (pos_d != pos_q);
    assign state_o   = state_q;

endmodule

// File: rtl/turkey_gun_ctrl.sv
// Joystick to absolute gun crosshair converter feeding the williams2 gun
// inputs. Movement is paced by rising edges of the core's cnt_4ms level.
//
// Ports:
//   clk_sys     system clock (12 MHz domain)
//   reset_n     synchronous active-low reset
//   cnt_4ms     pacing level; each rising edge is one movement tick
//   joy_left/right/up/down  held directions (active high)
//   recenter    snap both axes to GUN_CENTER
//   gun_h       horizontal position, 0 = left edge
//   gun_v       vertical position, 0 = top edge
//   gun_update  one-cycle pulse in the first cycle a new position is visible
//   gun_state   debug: {vertical FSM state, horizontal FSM state}
module turkey_gun_ctrl
    import turkey_gun_pkg::*;
#(
    parameter int GUN_MAX     = GUN_MAX_C,
    parameter int GUN_CENTER  = GUN_CENTER_C,
    parameter int DIV_SLOW    = 3,
    parameter int DIV_FAST    = 1,
    parameter int ACCEL_TICKS = 16
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cnt_4ms,
    input  logic       joy_left,
    input  logic       joy_right,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       recenter,
    output logic [5:0] gun_h,
    output logic [5:0] gun_v,
    output logic       gun_update,
    output logic [3:0] gun_state
);

    logic        cnt_4ms_q;
    logic        tick;
    logic        h_changed, v_changed;
    logic        update_q, update_d;
    axis_state_t h_state, v_state;

    assign tick     = cnt_4ms & ~cnt_4ms_q;
    // Simultaneous H and V moves share one pulse.
    assign update_d = h_changed | v_changed;

    gun_axis #(
        .GUN_MAX    (GUN_MAX),
        .GUN_CENTER (GUN_CENTER),
        .DIV_SLOW   (DIV_SLOW),
        .DIV_FAST   (DIV_FAST),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_h (
        .clk_i     (clk_sys),
        .rst_ni    (reset_n),
        .tick_i    (tick),
        .recenter_i(recenter),
        .plus_i    (joy_right),
        .minus_i   (joy_left),
        .pos_o     (gun_h),
        .changed_o (h_changed),
        .state_o   (h_state)
    );

    gun_axis #(
        .GUN_MAX    (GUN_MAX),
        .GUN_CENTER (GUN_CENTER),
        .DIV_SLOW   (DIV_SLOW),
        .DIV_FAST   (DIV_FAST),
        .ACCEL_TICKS(ACCEL_TICKS)
    ) u_axis_v (
        .clk_i     (clk_sys),
        .rst_ni    (reset_n),
        .tick_i    (tick),
        .recenter_i(recenter),
        .plus_i    (joy_down),
        .minus_i   (joy_up),
        .pos_o     (gun_v),
        .changed_o (v_changed),
        .state_o   (v_state)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_4ms_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            cnt_4ms_q <= cnt_4ms;
            update_q  <= update_d;
        end
    end

    assign gun_update = update_q;
    assign gun_state  = {v_state, h_state};

endmodule

// File: tb/tb_turkey_gun_ctrl.sv
// Directed bench for turkey_gun_ctrl. Expected {gun_h, gun_v} values are
// queued when a tick is issued; a monitor pops one entry per gun_update pulse.
module tb_turkey_gun_ctrl;
    import turkey_gun_pkg::*;

    logic       clk_sys;
    logic       reset_n;
    logic       cnt_4ms;
    logic       joy_left, joy_right, joy_up, joy_down;
    logic       recenter;
    logic [5:0] gun_h, gun_v;
    logic       gun_update;
    logic [3:0] gun_state;

    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int mark   = 0;

    turkey_gun_ctrl dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cnt_4ms   (cnt_4ms),
        .joy_left  (joy_left),
        .joy_right (joy_right),
        .joy_up    (joy_up),
        .joy_down  (joy_down),
        .recenter  (recenter),
        .gun_h     (gun_h),
        .gun_v     (gun_v),
        .gun_update(gun_update),
        .gun_state (gun_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Number of steps after ticks 0..k with one direction held from IDLE,
    // default parameters: step on tick 0, then every 3rd tick up to tick 15,
    // no step on promotion tick 16, then one step per tick.
    function automatic int steps_after(input int k);
        if (k <= 15) return 1 + k / 3;
        else if (k == 16) return 6;
        else return 6 + (k - 16);
    endfunction

    function automatic int clamp_pos(input int p);
        if (p > 62) return 62;
        if (p < 0) return 0;
        return p;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_sys) begin
        if (reset_n && gun_update) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got h=%0d v=%0d expected no pulse", gun_h, gun_v);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({gun_h, gun_v} != e) begin
                    errors++;
                    $display("FAIL update_value: got h=%0d v=%0d expected h=%0d v=%0d",
                             gun_h, gun_v, e[11:6], e[5:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_joy(input logic l, input logic r, input logic u, input logic d);
        joy_left  = l;
        joy_right = r;
        joy_up    = u;
        joy_down  = d;
    endtask

    // One tick: rising edge of cnt_4ms, new value visible one edge later.
    task automatic do_tick(input int eh, input int ev, input bit upd, input string tag);
        if (upd) exp_q.push_back({6'(eh), 6'(ev)});
        @(negedge clk_sys);
        cnt_4ms = 1'b1;
        @(negedge clk_sys);
        cnt_4ms = 1'b0;
        check({tag, "_h"}, int'(gun_h), eh);
        check({tag, "_v"}, int'(gun_v), ev);
        @(negedge clk_sys);
    endtask

    task automatic do_recenter(input bit on_tick, input string tag);
        exp_q.push_back({6'd31, 6'd31});
        @(negedge clk_sys);
        recenter = 1'b1;
        if (on_tick) cnt_4ms = 1'b1;
        @(negedge clk_sys);
        recenter = 1'b0;
        cnt_4ms  = 1'b0;
        check({tag, "_h"}, int'(gun_h), 31);
        check({tag, "_v"}, int'(gun_v), 31);
        check({tag, "_state"}, int'(gun_state), 0);
        @(negedge clk_sys);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int eh, ev, prev;

        reset_n  = 1'b0;
        cnt_4ms  = 1'b0;
        recenter = 1'b0;
        set_joy(0, 1, 0, 0);

        // Reset held with right pressed and ticks toggling.
        @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            cnt_4ms = ~cnt_4ms;
            @(negedge clk_sys);
            check("reset_h", int'(gun_h), 31);
            check("reset_v", int'(gun_v), 31);
            check("reset_update", int'(gun_update), 0);
            check("reset_state", int'(gun_state), 0);
        end
        cnt_4ms = 1'b0;
        set_joy(0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        check("idle_after_reset_h", int'(gun_h), 31);

        // Acceleration ramp to the right edge, then 10 clamped ticks.
        set_joy(0, 1, 0, 0);
        mark = pulses;
        prev = 31;
        for (int k = 0; k <= 51; k++) begin
            eh = clamp_pos(31 + steps_after(k));
            do_tick(eh, 31, eh != prev, "ramp");
            prev = eh;
            if (k == 15) check("ramp_h_tick15", int'(gun_h), 37);
            if (k == 16) check("ramp_fast_state", int'(gun_state[1:0]), int'(AX_FAST));
            if (k == 20) begin
                check("ramp_h_tick20", int'(gun_h), 41);
                check("ramp_pulses", pulses - mark, 10);
            end
            if (k == 41) mark = pulses;
        end
        check("clamp_max_pulses", pulses - mark, 0);

        // Release, then ramp up to the top edge and hold there.
        set_joy(0, 0, 0, 0);
        do_tick(62, 31, 0, "release_r");
        set_joy(0, 0, 1, 0);
        prev = 31;
        for (int k = 0; k <= 50; k++) begin
            ev = clamp_pos(31 - steps_after(k));
            do_tick(62, ev, ev != prev, "ramp_up");
            prev = ev;
        end
        set_joy(0, 0, 0, 0);
        do_tick(62, 0, 0, "release_u");

        // Opposing inputs cancel.
        set_joy(1, 1, 0, 0);
        for (int k = 0; k < 5; k++) do_tick(62, 0, 0, "opposing");
        check("opposing_state", int'(gun_state[1:0]), int'(AX_IDLE));
        set_joy(0, 0, 0, 0);

        // Recenter off-tick, then reversal.
        do_recenter(0, "recenter_idle");
        set_joy(0, 1, 0, 0);
        do_tick(32, 31, 1, "rev0");
        do_tick(32, 31, 0, "rev1");
        do_tick(32, 31, 0, "rev2");
        do_tick(33, 31, 1, "rev3");
        set_joy(1, 0, 0, 0);
        do_tick(32, 31, 1, "reversal");
        check("reversal_state", int'(gun_state[1:0]), int'(AX_SLOW));
        set_joy(0, 0, 0, 0);
        do_tick(32, 31, 0, "rev_release");

        // Diagonal move to (50, 12), then up alone to (50, 10).
        do_recenter(0, "recenter_pre");
        set_joy(0, 1, 1, 0);
        prev = 0;
        for (int k = 0; k <= 29; k++) begin
            do_tick(31 + steps_after(k), 31 - steps_after(k),
                    steps_after(k) != prev, "diag");
            prev = steps_after(k);
        end
        set_joy(0, 0, 1, 0);
        do_tick(50, 11, 1, "up_only1");
        do_tick(50, 10, 1, "up_only2");

        // Recenter on a tick with up held: single pulse, ramp restarts.
        mark = pulses;
        do_recenter(1, "recenter_tick");
        check("recenter_pulses", pulses - mark, 1);
        do_tick(31, 30, 1, "after_recenter");

        // cnt_4ms held high: only the rising edge moves.
        set_joy(0, 0, 0, 0);
        do_tick(31, 30, 0, "pre_hold");
        set_joy(0, 1, 0, 0);
        mark = pulses;
        exp_q.push_back({6'd32, 6'd30});
        @(negedge clk_sys);
        cnt_4ms = 1'b1;
        repeat (1000) @(negedge clk_sys);
        check("hold_high_h", int'(gun_h), 32);
        check("hold_high_v", int'(gun_v), 30);
        check("hold_high_pulses", pulses - mark, 1);
        cnt_4ms = 1'b0;
        set_joy(0, 0, 0, 0);

        repeat (5) @(negedge clk_sys);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
